array_serializer: RTL and testbench
===================================

# array_serializer

Parametrised, double-buffered successor to the single-slot array-to-byte dumper. It accepts a whole ARRAY_HEIGHT x ARRAY_WIDTH x CELL_WIDTH array in one handshake and emits it as a valid/ready stream of OUT_WIDTH-bit beats. Four features are new over the single-slot block:
- selectable beat order;
- per-array runtime length (partial dumps);
- two storage slots, so the next array is accepted while the current one streams;
- back-to-back arrays leave no bubble on the output.

It sits between compute arrays and the UART/host-link byte path.

## Interface
Parameters:
- ARRAY_HEIGHT, 16, array rows
- ARRAY_WIDTH, 3, array columns
- CELL_WIDTH, 8, bits per cell
- OUT_WIDTH, 8, bits per output beat; TOTAL = ARRAY_HEIGHT*ARRAY_WIDTH*CELL_WIDTH must be a multiple of OUT_WIDTH (elaboration-time error otherwise)
- MSB_FIRST, 0, 0: beat k = in_data[k*OUT_WIDTH +: OUT_WIDTH]; 1: beat k = in_data[(BEATS-1-k)*OUT_WIDTH +: OUT_WIDTH]

Derived: BEATS = TOTAL/OUT_WIDTH; LEN_BITS = $clog2(BEATS+1).

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  TOTAL  array to send
- in_length  in  LEN_BITS  beats to send; 0 or any value >= BEATS means BEATS
- in_valid  in  1  input handshake valid
- in_ready  out  1  at least one slot free
- out_data  out  OUT_WIDTH  current beat
- out_valid  out  1  a slot is streaming
- out_ready  in  1  downstream accepts beat
- out_last  out  1  current beat is the final beat of its array

## Operation
- Storage per slot: data[TOTAL-1:0] and len[LEN_BITS-1:0]. len holds the effective length, 1..BEATS, clamped at write time.
- Pointer and occupancy state:
  - wr_ptr and rd_ptr are 1-bit slot pointers.
  - count is the number of full slots, 0..2.
  - idx is the beat index within slot rd_ptr, 0..BEATS-1.
- Output and ready decode:
  - in_ready = (count != 2). This is a registered decode only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data = the selected beat of slot rd_ptr at index idx, ordered by MSB_FIRST.
  - out_last = out_valid && (idx == len[rd_ptr]-1).
- Accept (in_valid && in_ready): write in_data and the clamped length into slot wr_ptr, toggle wr_ptr, increment count.
- Send, non-last beat (out_valid && out_ready && !out_last): idx increments.
- Send, last beat (out_valid && out_ready && out_last): idx returns to 0, rd_ptr toggles, count decrements.
- Accept and last-send in the same cycle: count is unchanged and both pointers toggle.
- Accept with count==1 while a slot is streaming: the streaming slot is unaffected. The write never targets slot rd_ptr while count>0.
- While count==0, idx is held at 0.
- in_length is sampled only on the accepting edge. Slot contents are stable until that slot's last beat is sent.
- Length 1 gives a single beat with out_last high.
- Beat order within a slot runs from idx 0 upward. Only the mapping of idx to bit position changes with MSB_FIRST.

## Timing
- Reset (reset_n low, asynchronous assert; release is synchronised upstream):
  - count=0, wr_ptr=rd_ptr=0, idx=0, all slot data and lengths 0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0.
- Reset asserted mid-stream discards both slots immediately; no further beats are emitted.
- Latency: an array accepted at edge N into an empty block has beat 0 valid in the cycle after edge N.
- Throughput: one beat per cycle while out_ready is high. Across consecutive arrays with count==2, the last beat of slot A is followed in the next cycle by beat 0 of slot B, with no bubble.
- out_data and out_last hold stable while out_valid && !out_ready.
- in_ready falls on the edge where count reaches 2. It rises on the edge after the last beat of the streaming slot is accepted.

## Test plan
- Defaults (384 bits, 48 beats, LSB-first): send in_data with byte k = k, in_length=0 and out_ready=1 -> 48 beats 0x00..0x2F, out_last only on 0x2F, out_valid low on the following cycle.
- MSB_FIRST=1 with the same data -> beats 0x2F down to 0x00, out_last on 0x00.
- Back-to-back: present arrays A (bytes 0xA0+k) and B (bytes 0xB0+k) on consecutive cycles with out_ready=1 -> both accepted, in_ready low while count==2, 96 contiguous beats, B beat 0 immediately after A's last beat.
- Partial and clamped lengths: in_length=5 -> 5 beats with out_last on the 5th; in_length=1 -> 1 beat with out_last; in_length=60 -> 48 beats.
- Backpressure: toggle out_ready pseudo-randomly at 50% -> out_data and out_last stable while stalled, beat order intact, no beat lost or duplicated (scoreboard).
- Reset mid-stream: assert reset_n low at beat 20 with one slot queued -> out_valid, out_last and out_data go to 0 and in_ready to 1 immediately; after release, a new array streams from beat 0 with no stale beats.

Source files
------------

// File: rtl/array_serializer.sv
// array_serializer: double-buffered array-to-beat serializer.
// One handshake accepts a whole ARRAY_HEIGHT x ARRAY_WIDTH x CELL_WIDTH array.
// The array is streamed as OUT_WIDTH-bit beats. Each array carries its own
// runtime length. While one slot streams, the other slot can be refilled, so
// consecutive arrays leave no gap on the output.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_data     array to send (TOTAL bits)
//   in_length   beats to send; 0 or >= BEATS sends all BEATS beats
//   in_valid    input handshake valid
//   in_ready    at least one slot is free (registered decode)
//   out_data    current beat of the streaming slot
//   out_valid   a slot is streaming
//   out_ready   downstream accepts the beat
//   out_last    current beat is the final beat of its array
module array_serializer #(
    parameter int unsigned ARRAY_HEIGHT = 16,
    parameter int unsigned ARRAY_WIDTH  = 3,
    parameter int unsigned CELL_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter bit          MSB_FIRST    = 1'b0,
    localparam int unsigned TOTAL    = ARRAY_HEIGHT * ARRAY_WIDTH * CELL_WIDTH,
    localparam int unsigned BEATS    = TOTAL / OUT_WIDTH,
    localparam int unsigned LEN_BITS = $clog2(BEATS + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [TOTAL-1:0]     in_data,
    input  logic [LEN_BITS-1:0]  in_length,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int unsigned IDX_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LEN_BITS-1:0] BEATS_LEN = LEN_BITS'(BEATS);
    localparam logic [IDX_BITS-1:0] LAST_BEAT = IDX_BITS'(BEATS - 1);

    // The array must split into a whole number of beats.
    if ((TOTAL % OUT_WIDTH) != 0) begin : g_width_check
        $error("array_serializer: TOTAL must be a multiple of OUT_WIDTH");
    end

    // Slot storage: each slot is viewed as BEATS packed beats.
    logic [BEATS-1:0][OUT_WIDTH-1:0] slot_data [2];
    logic [LEN_BITS-1:0]             slot_len  [2];

    // Pointer and occupancy state.
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [IDX_BITS-1:0] idx;

    logic                wr_ptr_n;
    logic                rd_ptr_n;
    logic [1:0]          count_n;
    logic [IDX_BITS-1:0] idx_n;

    logic                accept;
    logic                send;
    logic                send_last;
    logic [LEN_BITS-1:0] eff_len;
    logic [IDX_BITS-1:0] last_idx;
    logic [IDX_BITS-1:0] beat_sel;

    // Handshake decode and output beat selection.
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);

        // Length is clamped once at write time so the read side sees 1..BEATS.
        eff_len = ((in_length == '0) || (in_length >= BEATS_LEN)) ? BEATS_LEN : in_length;

        last_idx = IDX_BITS'(slot_len[rd_ptr] - LEN_BITS'(1));
        out_last = out_valid && (idx == last_idx);

        // Beat order always advances from idx 0; only the bit position mirrors.
        beat_sel = MSB_FIRST ? (LAST_BEAT - idx) : idx;
        out_data = out_valid ? slot_data[rd_ptr][beat_sel] : '0;

        accept    = in_valid && in_ready;
        send      = out_valid && out_ready;
        send_last = send && out_last;
    end

    // Next-state for pointers, occupancy and beat index.
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        idx_n    = idx;

        if (accept) begin
            wr_ptr_n = ~wr_ptr;
        end
        if (send_last) begin
            rd_ptr_n = ~rd_ptr;
        end

        unique case ({accept, send_last})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase

        if (send_last) begin
            idx_n = '0;
        end else if (send) begin
            idx_n = idx + IDX_BITS'(1);
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            idx    <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            idx    <= idx_n;
        end
    end

    // Slot write; never targets the streaming slot because in_ready implies a free slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                slot_data[s] <= '0;
                slot_len[s]  <= '0;
            end
        end else if (accept) begin
            slot_data[wr_ptr] <= in_data;
            slot_len[wr_ptr]  <= eff_len;
        end
    end

endmodule

// File: tb/tb_array_serializer.sv
module tb_array_serializer;

    localparam int unsigned TOTAL    = 384;
    localparam int unsigned BEATS    = 48;
    localparam int unsigned LEN_BITS = 6;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [TOTAL-1:0]   in_data;
    logic [LEN_BITS-1:0] in_length;
    logic               in_valid;
    logic               out_ready;
    logic               in_ready, out_valid, out_last;
    logic [7:0]         out_data;
    logic               m_in_ready, m_out_valid, m_out_last;
    logic [7:0]         m_out_data;

    array_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_length(in_length),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    array_serializer #(.MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_length(in_length),
        .in_valid(in_valid), .in_ready(m_in_ready), .out_data(m_out_data),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_last(m_out_last)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: expected beat stream, built from each accepted array.
    logic [7:0] exp_lsb[$];
    logic [7:0] exp_msb[$];
    bit         exp_last[$];
    // Observed stream.
    logic [7:0] obs_lsb[$];
    logic [7:0] obs_msb[$];
    bit         obs_last[$];
    int         obs_cyc[$];
    bit         ir_hist[$];
    int         acc_cyc[$];
    int         stall_viol;
    int         lockstep_viol;

    function automatic int clamp_len(input int len);
        return (len == 0 || len >= int'(BEATS)) ? int'(BEATS) : len;
    endfunction

    function automatic logic [TOTAL-1:0] rand_arr();
        logic [TOTAL-1:0] a;
        for (int k = 0; k < int'(BEATS); k++) a[k*8 +: 8] = 8'($urandom);
        return a;
    endfunction

    function automatic void model_push(input logic [TOTAL-1:0] arr, input int len);
        int l = clamp_len(len);
        for (int k = 0; k < l; k++) begin
            exp_lsb.push_back(arr[k*8 +: 8]);
            exp_msb.push_back(arr[(int'(BEATS) - 1 - k)*8 +: 8]);
            exp_last.push_back(k == l - 1);
        end
    endfunction

    function automatic void clear_all();
        exp_lsb.delete(); exp_msb.delete(); exp_last.delete();
        obs_lsb.delete(); obs_msb.delete(); obs_last.delete(); obs_cyc.delete();
        ir_hist.delete(); acc_cyc.delete();
        stall_viol = 0;
        lockstep_viol = 0;
    endfunction

    function automatic int count_diff();
        int n;
        int m;
        m = (obs_lsb.size() < exp_lsb.size()) ? obs_lsb.size() : exp_lsb.size();
        n = (obs_lsb.size() > exp_lsb.size()) ? obs_lsb.size() - exp_lsb.size()
                                              : exp_lsb.size() - obs_lsb.size();
        for (int i = 0; i < m; i++)
            if (obs_lsb[i] !== exp_lsb[i] || obs_msb[i] !== exp_msb[i] || obs_last[i] !== exp_last[i])
                n++;
        return n;
    endfunction

    function automatic int last_count();
        int n = 0;
        foreach (obs_last[i]) if (obs_last[i]) n++;
        return n;
    endfunction

    function automatic int gap_count();
        int n = 0;
        for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) n++;
        return n;
    endfunction

    // Present one array starting at the current negedge; returns after acceptance.
    task automatic load(input logic [TOTAL-1:0] arr, input int len, input int max_wait, output bit ok);
        ok = 1'b0;
        in_data   = arr;
        in_length = LEN_BITS'(len);
        in_valid  = 1'b1;
        for (int w = 0; w < max_wait; w++) begin
            if (in_ready) begin
                ok = 1'b1;
                acc_cyc.push_back(cyc);
                model_push(arr, len);
            end
            @(posedge clock);
            if (ok) break;
            @(negedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Drive out_ready and record every accepted beat until target beats or budget.
    task automatic collect(input int target, input int budget, input int ready_pct);
        bit         pst = 1'b0;
        logic [7:0] pd = '0, pm = '0;
        bit         pl = 1'b0;
        for (int c = 0; c < budget && obs_lsb.size() < target; c++) begin
            @(negedge clock);
            ir_hist.push_back(in_ready);
            if (m_out_valid !== out_valid || m_out_last !== out_last || m_in_ready !== in_ready)
                lockstep_viol++;
            if (pst && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || m_out_data !== pm))
                stall_viol++;
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && out_ready) begin
                obs_lsb.push_back(out_data);
                obs_msb.push_back(m_out_data);
                obs_last.push_back(out_last);
                obs_cyc.push_back(cyc);
            end
            pst = out_valid && !out_ready;
            pd  = out_data;
            pm  = m_out_data;
            pl  = out_last;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_length = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (m_out_data !== 8'h00) begin bad++; $display("FAIL reset_msb_out_data got=%h exp=00", m_out_data); end
        reset_n = 1'b1;
    endtask

    task automatic test_full_order();
        logic [TOTAL-1:0] arr;
        bit ok;
        for (int k = 0; k < int'(BEATS); k++) arr[k*8 +: 8] = 8'(k);
        clear_all();
        @(negedge clock);
        out_ready = 1'b1;
        fork
            load(arr, 0, 10, ok);
            collect(int'(BEATS), 200, 100);
        join
        total++; if (!ok) begin bad++; $display("FAIL full_accept got=0 exp=1"); end
        total++; if (obs_lsb.size() != 48) begin bad++; $display("FAIL full_beats got=%0d exp=48", obs_lsb.size()); end
        total++; if (count_diff() != 0) begin bad++; $display("FAIL full_stream mismatches=%0d exp=0", count_diff()); end
        total++; if (obs_lsb.size() != 48 || obs_lsb[0] !== 8'h00 || obs_lsb[47] !== 8'h2F)
            begin bad++; $display("FAIL full_lsb_ends got_size=%0d exp first=00 last=2F", obs_lsb.size()); end
        total++; if (obs_msb.size() != 48 || obs_msb[0] !== 8'h2F || obs_msb[47] !== 8'h00)
            begin bad++; $display("FAIL full_msb_ends got_size=%0d exp first=2F last=00", obs_msb.size()); end
        total++; if (last_count() != 1 || obs_last.size() != 48 || !obs_last[47])
            begin bad++; $display("FAIL full_last_pos lasts=%0d exp=1 on beat 47", last_count()); end
        total++; if (obs_cyc.size() == 0 || acc_cyc.size() == 0 || obs_cyc[0] != acc_cyc[0] + 1)
            begin bad++; $display("FAIL full_latency beat0_cyc=%0d exp=accept+1", obs_cyc.size() ? obs_cyc[0] : -1); end
        total++; if (gap_count() != 0) begin bad++; $display("FAIL full_gaps got=%0d exp=0", gap_count()); end
        total++; if (lockstep_viol != 0) begin bad++; $display("FAIL full_lockstep got=%0d exp=0", lockstep_viol); end
        @(negedge clock);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_idle_after got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [TOTAL-1:0] a, b;
        bit oka, okb;
        int lows;
        for (int k = 0; k < int'(BEATS); k++) begin
            a[k*8 +: 8] = 8'(8'hA0 + k);
            b[k*8 +: 8] = 8'(8'hB0 + k);
        end
        clear_all();
        @(negedge clock);
        out_ready = 1'b1;
        fork
            begin
                load(a, 0, 10, oka);
                load(b, 0, 10, okb);
            end
            collect(96, 400, 100);
        join
        lows = 0;
        foreach (ir_hist[i]) if (!ir_hist[i]) lows++;
        total++; if (!oka || !okb) begin bad++; $display("FAIL b2b_accept got=%b%b exp=11", oka, okb); end
        total++; if (acc_cyc.size() != 2 || acc_cyc[1] != acc_cyc[0] + 1)
            begin bad++; $display("FAIL b2b_consecutive_accepts n=%0d exp=2 adjacent", acc_cyc.size()); end
        total++; if (obs_lsb.size() != 96) begin bad++; $display("FAIL b2b_beats got=%0d exp=96", obs_lsb.size()); end
        total++; if (count_diff() != 0) begin bad++; $display("FAIL b2b_stream mismatches=%0d exp=0", count_diff()); end
        total++; if (gap_count() != 0) begin bad++; $display("FAIL b2b_bubbles got=%0d exp=0", gap_count()); end
        total++; if (lows != 47) begin bad++; $display("FAIL b2b_in_ready_low_cycles got=%0d exp=47", lows); end
        total++; if (obs_lsb.size() != 96 || obs_lsb[47] !== 8'hCF || obs_lsb[48] !== 8'hB0 || !obs_last[47] || !obs_last[95])
            begin bad++; $display("FAIL b2b_boundary size=%0d exp A-last=CF then B0", obs_lsb.size()); end
        total++; if (last_count() != 2) begin bad++; $display("FAIL b2b_last_count got=%0d exp=2", last_count()); end
    endtask

    task automatic test_lengths();
        int lens[3]  = '{5, 1, 60};
        int elens[3] = '{5, 1, 48};
        for (int t = 0; t < 3; t++) begin
            logic [TOTAL-1:0] arr;
            bit ok;
            arr = rand_arr();
            clear_all();
            @(negedge clock);
            out_ready = 1'b1;
            fork
                load(arr, lens[t], 10, ok);
                collect(elens[t], 200, 100);
            join
            total++; if (obs_lsb.size() != elens[t])
                begin bad++; $display("FAIL len%0d_beats got=%0d exp=%0d", lens[t], obs_lsb.size(), elens[t]); end
            total++; if (count_diff() != 0)
                begin bad++; $display("FAIL len%0d_stream mismatches=%0d exp=0", lens[t], count_diff()); end
            total++; if (last_count() != 1 || obs_last.size() == 0 || !obs_last[obs_last.size()-1])
                begin bad++; $display("FAIL len%0d_last lasts=%0d exp=1 at end", lens[t], last_count()); end
            @(negedge clock);
            total++; if (out_valid !== 1'b0)
                begin bad++; $display("FAIL len%0d_idle_after got=%b exp=0", lens[t], out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [TOTAL-1:0] arrs[8];
        int lens[8];
        int tgt = 0;
        int nok = 0;
        for (int i = 0; i < 8; i++) begin
            arrs[i] = rand_arr();
            case ($urandom_range(2))
                0:       lens[i] = 0;
                1:       lens[i] = int'($urandom_range(1, 47));
                default: lens[i] = int'($urandom_range(48, 63));
            endcase
            tgt += clamp_len(lens[i]);
        end
        clear_all();
        @(negedge clock);
        fork
            for (int i = 0; i < 8; i++) begin
                bit ok;
                repeat ($urandom_range(3)) @(negedge clock);
                load(arrs[i], lens[i], 1000, ok);
                if (ok) nok++;
            end
            collect(tgt, 20000, 50);
        join
        total++; if (nok != 8) begin bad++; $display("FAIL bp_accepts got=%0d exp=8", nok); end
        total++; if (obs_lsb.size() != tgt) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", obs_lsb.size(), tgt); end
        total++; if (count_diff() != 0) begin bad++; $display("FAIL bp_scoreboard mismatches=%0d exp=0", count_diff()); end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stall_stability got=%0d exp=0", stall_viol); end
        total++; if (lockstep_viol != 0) begin bad++; $display("FAIL bp_lockstep got=%0d exp=0", lockstep_viol); end
        total++; if (last_count() != 8) begin bad++; $display("FAIL bp_last_count got=%0d exp=8", last_count()); end
    endtask

    task automatic test_reset_mid();
        logic [TOTAL-1:0] a, b, c;
        bit oka, okb, okc;
        a = rand_arr();
        b = rand_arr();
        c = rand_arr();
        clear_all();
        @(negedge clock);
        out_ready = 1'b1;
        fork
            begin
                load(a, 0, 10, oka);
                load(b, 0, 10, okb);
            end
            collect(20, 200, 100);
        join
        total++; if (obs_lsb.size() != 20 || obs_lsb[19] !== a[19*8 +: 8])
            begin bad++; $display("FAIL rst_pre_beats size=%0d exp=20 ending in %h", obs_lsb.size(), a[19*8 +: 8]); end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_mid_out_last got=%b exp=0", out_last); end
        total++; if (out_data !== 8'h00 || m_out_data !== 8'h00)
            begin bad++; $display("FAIL rst_mid_out_data got=%h/%h exp=00/00", out_data, m_out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        clear_all();
        fork
            load(c, 0, 10, okc);
            collect(int'(BEATS), 200, 100);
        join
        total++; if (obs_lsb.size() != 48 || count_diff() != 0)
            begin bad++; $display("FAIL rst_post_stream size=%0d mismatches=%0d exp=48/0", obs_lsb.size(), count_diff()); end
        total++; if (obs_lsb.size() == 0 || obs_lsb[0] !== c[7:0])
            begin bad++; $display("FAIL rst_post_first got=%h exp=%h", obs_lsb.size() ? obs_lsb[0] : 8'h00, c[7:0]); end
        @(negedge clock);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_stale got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_full_order();
        test_back_to_back();
        test_lengths();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
